// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and constants for the iterative divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Widest divider this constant supports; the top slices it down to WIDTH.
    localparam int MAX_WIDTH = 64;

    // Quotient reported on divide-by-zero (all ones, i.e. -1).
    localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/sub_borrow_n.sv
// rtl/sub_borrow_n.sv - N-bit ripple subtractor a - b with borrow out
module sub_borrow_n #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] bw;

    assign bw[0] = 1'b0;

    // One full-subtractor cell per bit; the borrow ripples from LSB to MSB.
    for (genvar i = 0; i < N; i++) begin : g_cell
        assign diff[i]  = a[i] ^ b[i] ^ bw[i];
        assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end

    assign borrow = bw[N];

endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - restoring shift-subtract divider, one quotient bit per clock
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state_q, state_d;
    logic             load, take_div0, step, finish;

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic [CNT_W-1:0] cnt;
    logic             sign_q, sign_r;

    logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in;
    logic [WIDTH:0]   rem_shift, trial, rem_next;
    logic             trial_borrow;
    logic [WIDTH-1:0] quo_next, quo_fixed, rem_fixed;
    logic             unused_msbs;

    // Operand magnitudes, only folded when the operation is signed.
    assign dvd_mag_in = (is_signed && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
    assign dvs_mag_in = (is_signed && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;

    // Partial remainder shifted left, pulling in the next dividend bit from quo.
    assign rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};

    sub_borrow_n #(
        .N(WIDTH + 1)
    ) u_trial (
        .a      (rem_shift),
        .b      ({1'b0, dvs_mag}),
        .diff   (trial),
        .borrow (trial_borrow)
    );

    assign rem_next  = trial_borrow ? rem_shift : trial;
    assign quo_next  = {quo[WIDTH-2:0], ~trial_borrow};

    // Sign fix on the final iteration's values; -2^(WIDTH-1) wraps onto itself.
    assign quo_fixed = sign_q ? (~quo_next + WIDTH'(1)) : quo_next;
    assign rem_fixed = sign_r ? (~rem_next[WIDTH-1:0] + WIDTH'(1)) : rem_next[WIDTH-1:0];

    // The remainder never exceeds the divisor, so its top bit carries no information.
    assign unused_msbs = rem[WIDTH] ^ rem_next[WIDTH];

    assign busy  = (state_q == RUN);
    assign valid = (state_q == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and datapath control strobes.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        take_div0 = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (divisor == '0) begin
                        take_div0 = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration registers and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem         <= '0;
            quo         <= '0;
            dvs_mag     <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (load) begin
                rem     <= '0;
                quo     <= dvd_mag_in;
                dvs_mag <= dvs_mag_in;
                cnt     <= CNT_W'(WIDTH);
                sign_q  <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                sign_r  <= is_signed & dividend[WIDTH-1];
            end
            if (take_div0) begin
                quotient    <= DIV0_QUOTIENT[WIDTH-1:0];
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
            if (step) begin
                rem <= rem_next;
                quo <= quo_next;
                cnt <= cnt - CNT_W'(1);
            end
            if (finish) begin
                quotient    <= quo_fixed;
                remainder   <= rem_fixed;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule
